gemm3_bias_reader: RTL and testbench
====================================

# gemm3_bias_reader

Streams the layer-3 GEMM bias table out of the 128×64-bit bias ROM into the downstream bias-add datapath of the RL inference pipeline. On a start pulse it sweeps ROM addresses 0..DEPTH-1 and hides the ROM's one-cycle registered read latency behind a small credit-controlled FIFO. It presents each word on a valid/ready stream tagged with its index and a last flag. Each 64-bit word carries four FP16 bias lanes, which this block passes through unmodified.

## Interface
- DEPTH, 128: number of ROM words swept per run.
- AW, 7: ROM address width; must satisfy 2^AW ≥ DEPTH.
- DW, 64: ROM word width (4 × FP16 lanes).
- FIFO_DEPTH, 4: output buffer entries.

- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; ignored while busy.
- abort  in  1  cancel the current run and flush the buffer.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted, or after an abort.
- rom_addr  out  AW  address to the bias ROM, driven combinationally from issue_ptr.
- rom_data  in  DW  ROM output; holds data for the address driven in the previous cycle.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DW  bias word; lane k = m_data[16k+15:16k], k = 0..3.
- m_index  out  AW  ROM index of m_data.
- m_last  out  1  m_index == DEPTH-1.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE --start--> RUN: issue_ptr=0, pending=0, FIFO empty.
  - RUN: issue happens when occupancy + pending < FIFO_DEPTH, using registered values only. A pop in the same cycle does not free a credit until the next cycle.
  - An issue drives rom_addr=issue_ptr, sets pending for the next cycle, and increments issue_ptr.
  - After issuing DEPTH-1, RUN -> DRAIN.
  - DRAIN -> IDLE on the handshake of the last beat (m_valid & m_ready & m_last). done pulses in the following cycle.
- Capture: when pending=1, rom_data and its tag index (issue_ptr at issue time) are written into the FIFO at the end of that cycle. Writes never overflow because of the credit rule.
- FIFO is first-word registered: m_valid = !empty. m_data, m_index and m_last come from the head entry. Pop on m_valid & m_ready.
- m_valid, once high, holds with stable m_data and m_index until accepted.
- rom_addr holds its last issued value when not issuing. The ROM is read every cycle, but only issued reads are captured.
- abort (any state but IDLE): next cycle FIFO empty, pending=0, issue_ptr=0, state IDLE, m_valid=0, done=1 for one cycle. abort in IDLE has no effect.
- start and abort together: abort wins. start is ignored while busy.
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_index=0, m_data=0, rom_addr=0, state IDLE.
- rst mid-run gives the same flush as abort, without the done pulse.

## Timing
- start sampled high at the end of cycle 0 → rom_addr=0 issued in cycle 1 → rom_data=word0 in cycle 2, written at the end of cycle 2 → m_valid=1 with m_index=0 in cycle 3.
- Start-to-first-valid latency: 3 cycles.
- With m_ready held high, throughput is 1 word/cycle. A run of DEPTH words completes its last handshake in cycle DEPTH+2; done is high in cycle DEPTH+3.
- m_ready low for N cycles: issue stalls after at most FIFO_DEPTH words are buffered. No word is lost or duplicated, and ordering is strictly by index.
- busy rises the cycle after start and falls in the same cycle done pulses.

## Structure
- Shared package gemm3_pkg: GEMM3_DEPTH=128, GEMM3_AW=7, GEMM3_DW=64, FP16_W=16, LANES=4, and the reader state enum.
- One sub-module: gemm3_word_fifo, a synchronous FIFO of {AW index, DW data} with registered head, count output and flush input.
- The bias ROM is instantiated by the parent and connected via rom_addr/rom_data; this block does not contain it.

## Test plan
- Reset then start with m_ready=1 → m_valid first in cycle 3; 128 beats with m_index 0..127 matching the ROM model; m_last only on index 127; done in cycle 131.
- m_ready toggling 1,0,0,1 pattern → all 128 words in order, no duplicates. occupancy + pending never exceeds 4 (assertion).
- m_ready=0 from cycle 0 for 20 cycles → exactly 4 words buffered, issue_ptr=4, rom_addr stable at 3. Release → resumes at 1 word/cycle.
- abort at beat 50 → next cycle m_valid=0, done=1, busy=0. A start 2 cycles later restarts at index 0.
- start pulsed again at beat 10 of a run → ignored; the stream continues to index 127 with a single done.
- rst asserted mid-run with m_valid=1 → next cycle all outputs at reset values, no done. A subsequent start gives first valid 3 cycles later.

Source files
------------

// File: rtl/gemm3_pkg.sv
// Shared widths and reader FSM encoding for the layer-3 GEMM bias path.
package gemm3_pkg;
    localparam int FP16_W      = 16;
    localparam int LANES       = 4;
    localparam int GEMM3_DEPTH = 128;
    localparam int GEMM3_AW    = 7;
    localparam int GEMM3_DW    = LANES * FP16_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } reader_state_e;
endpackage

// File: rtl/gemm3_bias_reader_if.sv
// ROM read port plus indexed valid/ready bias stream between the reader and its neighbours.
interface gemm3_bias_reader_if import gemm3_pkg::*; #(
    parameter int AW = GEMM3_AW,
    parameter int DW = GEMM3_DW
);
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_index;
    logic          m_last;

    modport master (
        output rom_addr, m_valid, m_data, m_index, m_last,
        input  rom_data, m_ready
    );

    modport slave (
        input  rom_addr, m_valid, m_data, m_index, m_last,
        output rom_data, m_ready
    );
endinterface

// File: rtl/gemm3_word_fifo.sv
// Small synchronous FIFO of {index, word}; the head entry is read straight from storage registers.
module gemm3_word_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [W-1:0]                 wr_data,
    input  logic                         rd_en,
    output logic [W-1:0]                 rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (rd_en) rd_ptr <= bump(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is cleared on reset because the head drives m_data directly and must read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
endmodule

// File: rtl/gemm3_bias_reader.sv
// Sweeps the bias ROM once per start and streams each word with its index, hiding the ROM read latency.
module gemm3_bias_reader import gemm3_pkg::*; #(
    parameter int DEPTH      = GEMM3_DEPTH,
    parameter int AW         = GEMM3_AW,
    parameter int DW         = GEMM3_DW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    gemm3_bias_reader_if.master bus
);
    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]     FD       = (CW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    reader_state_e    state, state_nx;
    logic [AW-1:0]    issue_ptr, issue_ptr_nx, tag_idx, addr_q, rom_addr;
    logic             pending, issue, done_nx, pop, flush;
    logic [CW-1:0]    occ;
    logic             fifo_empty;
    logic [AW+DW-1:0] head;

    assign flush = abort && (state != ST_IDLE);
    assign pop   = bus.m_valid && bus.m_ready;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        issue_ptr_nx = issue_ptr;
        issue        = 1'b0;
        done_nx      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx     = ST_RUN;
                    issue_ptr_nx = '0;
                end
            end
            ST_RUN: begin
                // Credits use registered occupancy only; a same-cycle pop frees space next cycle.
                if (({1'b0, occ} + {{CW{1'b0}}, pending}) < FD) begin
                    issue        = 1'b1;
                    issue_ptr_nx = issue_ptr + AW'(1);
                    if (issue_ptr == LAST_IDX) state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && bus.m_last) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (flush) begin
            state_nx     = ST_IDLE;
            issue_ptr_nx = '0;
            issue        = 1'b0;
            done_nx      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            issue_ptr <= '0;
            pending   <= 1'b0;
            tag_idx   <= '0;
            addr_q    <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            issue_ptr <= issue_ptr_nx;
            pending   <= issue;
            tag_idx   <= issue_ptr;
            addr_q    <= rom_addr;
            done      <= done_nx;
        end
    end

    assign rom_addr     = issue ? issue_ptr : addr_q;
    assign bus.rom_addr = rom_addr;
    assign busy         = (state != ST_IDLE);

    gemm3_word_fifo #(
        .W     (AW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (pending),
        .wr_data ({tag_idx, bus.rom_data}),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (occ)
    );

    assign bus.m_valid = !fifo_empty;
    assign bus.m_index = head[AW+DW-1:DW];
    assign bus.m_data  = head[DW-1:0];
    assign bus.m_last  = (bus.m_index == LAST_IDX);

    a_credit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, occ} + {{CW{1'b0}}, pending}) <= FD);
endmodule

// File: tb/tb_gemm3_bias_reader.sv
// Bench for gemm3_bias_reader: ROM model, in-order scoreboard, scenario table and corner sequences.
module tb_gemm3_bias_reader;
    import gemm3_pkg::*;

    localparam int DEPTH   = GEMM3_DEPTH;
    localparam int M_HIGH  = 0;
    localparam int M_PAT   = 1;
    localparam int M_RAND  = 2;
    localparam int M_STALL = 3;

    typedef struct {
        string name;
        int    mode;
        bit    extra_start;
        int    exp_first;
        int    exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;

    gemm3_bias_reader_if bus ();

    gemm3_bias_reader dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [GEMM3_DW-1:0] rom [DEPTH];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_idx, beats, first_valid, done_cnt, done_cycle, s0;
    bit prev_stall = 1'b0;
    logic [GEMM3_AW-1:0] prev_idx;
    logic [GEMM3_DW-1:0] prev_data;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: the stream is simply rom[0..DEPTH-1] in order, last only on the final word.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_index", bus.m_index, prev_idx);
                check("hold_data", bus.m_data, prev_data);
            end
            if (bus.m_valid && first_valid < 0) first_valid = cycle - s0;
            if (bus.m_valid && bus.m_ready) begin
                check($sformatf("beat%0d_index", exp_idx), bus.m_index, exp_idx);
                check($sformatf("beat%0d_data", exp_idx), bus.m_data, rom[exp_idx % DEPTH]);
                check($sformatf("beat%0d_last", exp_idx), bus.m_last, (exp_idx == DEPTH - 1));
                exp_idx++;
                beats++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_idx   = bus.m_index;
            prev_data  = bus.m_data;
            if (done) begin
                done_cnt++;
                done_cycle = cycle - s0;
                check("busy_low_at_done", busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        bus.m_ready = 1'b1;
        repeat (n) tick();
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            M_PAT:   return (k % 4 == 0) || (k % 4 == 3);
            M_RAND:  return 1'($urandom_range(0, 1));
            M_STALL: return (k >= 20);
            default: return 1'b1;
        endcase
    endfunction

    // Leaves the bench one cycle after start was sampled (relative cycle 1).
    task automatic begin_run();
        exp_idx     = 0;
        beats       = 0;
        first_valid = -1;
        done_cnt    = 0;
        done_cycle  = -1;
        check("busy_before_start", busy, 0);
        s0    = cycle;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic stream(input int mode, input bit extra);
        bit sent = 1'b0;
        int k = 1;
        while (done_cnt == 0 && k < 1500) begin
            bus.m_ready = ready_for(mode, k);
            start = 1'b0;
            if (extra && !sent && beats >= 10) begin
                start = 1'b1;
                sent  = 1'b1;
            end
            if (mode == M_STALL && (k == 10 || k == 19))
                check($sformatf("stall_rom_addr_c%0d", k), bus.rom_addr, 3);
            if (mode == M_STALL && k == 19) begin
                check("stall_buffered", dut.u_fifo.count, 4);
                check("stall_issue_ptr", dut.issue_ptr, 4);
                check("stall_valid", bus.m_valid, 1);
                check("stall_head_index", bus.m_index, 0);
            end
            tick();
            k++;
        end
        start = 1'b0;
        check("done_before_timeout", (done_cnt != 0), 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = {$urandom, $urandom};
        bus.m_ready = 1'b0;

        vecs[0] = '{"ready_high",      M_HIGH,  1'b0, 3, DEPTH + 3};
        vecs[1] = '{"ready_1001",      M_PAT,   1'b0, 3, -1};
        vecs[2] = '{"ready_random",    M_RAND,  1'b0, 3, -1};
        vecs[3] = '{"restart_ignored", M_HIGH,  1'b1, 3, DEPTH + 3};
        vecs[4] = '{"stall_20",        M_STALL, 1'b0, 3, DEPTH + 20};

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_m_index", bus.m_index, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_rom_addr", bus.rom_addr, 0);

        for (int v = 0; v < 5; v++) begin
            bus.m_ready = ready_for(vecs[v].mode, 0);
            begin_run();
            stream(vecs[v].mode, vecs[v].extra_start);
            settle(4);
            check({vecs[v].name, "_beats"}, beats, DEPTH);
            check({vecs[v].name, "_done_count"}, done_cnt, 1);
            check({vecs[v].name, "_first_valid"}, first_valid, vecs[v].exp_first);
            if (vecs[v].exp_done >= 0)
                check({vecs[v].name, "_done_cycle"}, done_cycle, vecs[v].exp_done);
        end

        // Abort after 50 accepted beats, then restart two cycles after the abort.
        bus.m_ready = 1'b1;
        begin_run();
        for (int k = 0; k < 400 && beats < 50; k++) tick();
        bus.m_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        prev_stall = 1'b0;
        check("abort_m_valid", bus.m_valid, 0);
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_beats", beats, 50);
        tick();
        check("abort_done_single", done, 0);
        bus.m_ready = 1'b1;
        begin_run();
        stream(M_HIGH, 1'b0);
        settle(4);
        check("after_abort_first_valid", first_valid, 3);
        check("after_abort_beats", beats, DEPTH);
        check("after_abort_done_count", done_cnt, 1);
        check("after_abort_done_cycle", done_cycle, DEPTH + 3);

        // Reset while a word is waiting on the output.
        bus.m_ready = 1'b0;
        begin_run();
        repeat (3) tick();
        check("pre_rst_valid", bus.m_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_stall = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_m_valid", bus.m_valid, 0);
        check("midrst_m_last", bus.m_last, 0);
        check("midrst_m_index", bus.m_index, 0);
        check("midrst_m_data", bus.m_data, 0);
        check("midrst_rom_addr", bus.rom_addr, 0);
        tick();
        tick();
        check("midrst_no_done", done_cnt, 0);
        bus.m_ready = 1'b1;
        begin_run();
        stream(M_HIGH, 1'b0);
        settle(4);
        check("after_rst_first_valid", first_valid, 3);
        check("after_rst_beats", beats, DEPTH);
        check("after_rst_done_count", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
